// File: rtl/membus_arbiter_pkg.sv
// Shared types for the I/D memory-bus arbiter.
//   MemSrc       : which master owns a request / response (fetch or data)
//   lock_state_e : arbiter mux lock state
//   ptr_width()  : pointer width helper that stays >= 1 for single-entry FIFOs
package eei;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } MemSrc;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  localparam int unsigned DEF_ADDR_WIDTH      = 64;
  localparam int unsigned DEF_DATA_WIDTH      = 64;
  localparam int unsigned DEF_MAX_OUTSTANDING = 2;
  localparam int unsigned DEF_STARVE_LIMIT    = 4;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/membus_tag_fifo.sv
// Small synchronous FIFO holding the source tag of every accepted request,
// so in-order responses can be steered back to the right master.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   push, din    : enqueue din (ignored when full)
//   pop          : dequeue head (ignored when empty)
//   head         : oldest entry
//   full, empty  : occupancy flags
module membus_tag_fifo
  import eei::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/membus_arbiter.sv
// Two-master arbiter (instruction fetch I, data/AMO D) in front of the single
// core-side request port of mmio_controller. Up to MAX_OUTSTANDING requests
// may be in flight; responses return in order and are steered by a tag FIFO.
// Data wins by default; a starvation timer forces one fetch grant.
// Ports:
//   clk, rst                         : clock, asynchronous active-low reset
//   i_valid/i_ready/i_addr           : fetch request
//   i_rvalid/i_rdata                 : fetch response
//   d_valid/d_ready/d_addr/d_wen/
//   d_wdata/d_wmask                  : data request
//   d_rvalid/d_rdata                 : data response
//   m_valid/m_ready/m_addr/m_wen/
//   m_wdata/m_wmask                  : muxed request to mmio_controller
//   m_rvalid/m_rdata                 : in-order response from mmio_controller
//
// Lock FSM:
//   state     | meaning
//   LOCK_IDLE | grant chosen freshly each cycle by priority
//   LOCK_HELD | target stalled a presented request; mux pinned to lock_src_q
module membus_arbiter
  import eei::*;
#(
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned STARVE_LIMIT    = DEF_STARVE_LIMIT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic                    d_wen,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic                    m_wen,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wmask,
  input  logic                    m_rvalid,
  input  logic [DATA_WIDTH-1:0]   m_rdata
);

  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  lock_state_e      lock_q, lock_d;
  MemSrc            lock_src_q, lock_src_d;
  // Cycles of fetch waiting still allowed before fetch is forced through;
  // reaching zero is the terminal count.
  logic [STV_W-1:0] starve_left_q, starve_left_d;

  MemSrc            grant;
  MemSrc            fifo_head;
  logic [0:0]       head_bits;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             i_accept;

  always_comb begin
    grant = SRC_I;
    if (lock_q == LOCK_HELD) begin
      grant = lock_src_q;
    end else if ((starve_left_q == '0) && i_valid) begin
      grant = SRC_I;
    end else if (d_valid) begin
      grant = SRC_D;
    end
  end

  // Full is taken from the registered count only, so a response arriving
  // this cycle cannot open a slot combinationally.
  assign m_valid  = rst & (i_valid | d_valid) & ~fifo_full;
  assign i_ready  = rst & m_ready & ~fifo_full & (grant == SRC_I);
  assign d_ready  = rst & m_ready & ~fifo_full & (grant == SRC_D);
  assign accept   = m_valid & m_ready;
  assign i_accept = accept & (grant == SRC_I);

  // Fetch grants drive clean zeros on the write side.
  always_comb begin
    m_addr  = i_addr;
    m_wen   = 1'b0;
    m_wdata = '0;
    m_wmask = '0;
    if (grant == SRC_D) begin
      m_addr  = d_addr;
      m_wen   = d_wen;
      m_wdata = d_wdata;
      m_wmask = d_wmask;
    end
  end

  membus_tag_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (grant),
    .pop   (m_rvalid),
    .head  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign fifo_head = MemSrc'(head_bits);
  // A response with nothing outstanding (e.g. left over from before a reset)
  // is dropped here.
  assign i_rvalid  = m_rvalid & ~fifo_empty & (fifo_head == SRC_I);
  assign d_rvalid  = m_rvalid & ~fifo_empty & (fifo_head == SRC_D);
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;

  always_comb begin
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (lock_q == LOCK_IDLE) begin
      if (m_valid && !m_ready) begin
        lock_d     = LOCK_HELD;
        lock_src_d = grant;
      end
    end else if (accept) begin
      lock_d = LOCK_IDLE;
    end
  end

  always_comb begin
    starve_left_d = starve_left_q;
    if (!i_valid || i_accept) begin
      starve_left_d = STV_W'(STARVE_LIMIT);
    end else if (starve_left_q != '0) begin
      starve_left_d = starve_left_q - STV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q        <= LOCK_IDLE;
      lock_src_q    <= SRC_I;
      starve_left_q <= STV_W'(STARVE_LIMIT);
    end else begin
      lock_q        <= lock_d;
      lock_src_q    <= lock_src_d;
      starve_left_q <= starve_left_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && m_rvalid) begin
      assert (!fifo_empty)
        else $warning("membus_arbiter: response with no outstanding request dropped");
    end
  end

endmodule

// File: tb/tb_membus_arbiter.sv
module tb_membus_arbiter;

  localparam int MAXO  = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready, i_rvalid;
  logic [63:0] i_addr, i_rdata;
  logic        d_valid, d_ready, d_wen, d_rvalid;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic [7:0]  d_wmask;
  logic        m_valid, m_ready, m_wen, m_rvalid;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [7:0]  m_wmask;

  always #5 clk = ~clk;

  membus_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_addr   (i_addr),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_addr   (d_addr),
    .d_wen    (d_wen),
    .d_wdata  (d_wdata),
    .d_wmask  (d_wmask),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_addr   (m_addr),
    .m_wen    (m_wen),
    .m_wdata  (m_wdata),
    .m_wmask  (m_wmask),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model: list of outstanding owners (0 = fetch, 1 = data),
  // how long fetch has been waiting, and which owner a stalled request has.
  bit q[$];
  int i_wait  = 0;
  int stalled = -1;
  bit exp_pres;
  bit exp_src;
  bit acc_i, acc_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
      else begin
        nerr++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic settle();
    bit ir, dr;
    #1;
    if (!rst) begin
      exp_pres = 1'b0;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_i_ready", i_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_i_rvalid", i_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
    end else begin
      exp_pres = (i_valid || d_valid) && (q.size() < MAXO);
      if (stalled >= 0)                   exp_src = (stalled == 1);
      else if (i_wait >= LIMIT && i_valid) exp_src = 1'b0;
      else if (d_valid)                   exp_src = 1'b1;
      else                                exp_src = 1'b0;
      chk("m_valid", m_valid, exp_pres);
      chk("i_ready", i_ready, m_ready && q.size() < MAXO && !exp_src);
      chk("d_ready", d_ready, m_ready && q.size() < MAXO && exp_src);
      chk("m_addr", m_addr, exp_src ? d_addr : i_addr);
      chk("m_wen", m_wen, exp_src ? d_wen : 1'b0);
      chk("m_wdata", m_wdata, exp_src ? d_wdata : 64'h0);
      chk("m_wmask", m_wmask, exp_src ? d_wmask : 8'h0);
      ir = m_rvalid && q.size() > 0 && !q[0];
      dr = m_rvalid && q.size() > 0 && q[0];
      chk("i_rvalid", i_rvalid, ir);
      chk("d_rvalid", d_rvalid, dr);
      chk("i_rdata", i_rdata, m_rdata);
      chk("d_rdata", d_rdata, m_rdata);
    end
  endtask

  task automatic tick();
    bit acc;
    @(posedge clk);
    acc_i = 1'b0;
    acc_d = 1'b0;
    if (!rst) begin
      q.delete();
      i_wait  = 0;
      stalled = -1;
    end else begin
      acc = exp_pres && m_ready;
      if (m_rvalid && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(exp_src);
      acc_i = acc && !exp_src;
      acc_d = acc && exp_src;
      if (exp_pres && !m_ready) stalled = exp_src ? 1 : 0;
      else if (acc)             stalled = -1;
      if (!i_valid || acc_i)    i_wait = 0;
      else if (i_wait < LIMIT)  i_wait++;
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    bit i_pend, d_pend;

    // Reset with every input active: outputs must stay quiet.
    rst = 1'b0;
    i_valid = 1'b1; i_addr = 64'h1000; d_valid = 1'b1; d_addr = 64'h2000;
    d_wen = 1'b1; d_wdata = 64'hdead_beef; d_wmask = 8'hff;
    m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 64'h55;
    @(negedge clk);
    step();
    step();
    i_valid = 1'b0; d_valid = 1'b0; d_wen = 1'b0; d_wdata = '0; d_wmask = '0;
    m_ready = 1'b0; m_rvalid = 1'b0;
    rst = 1'b1;
    step();

    // Single fetch.
    i_valid = 1'b1; i_addr = 64'h8000_0000; m_ready = 1'b1;
    settle();
    chk("t1_i_ready", i_ready, 1);
    chk("t1_m_addr", m_addr, 64'h8000_0000);
    tick();
    i_valid = 1'b0; m_rvalid = 1'b1; m_rdata = 64'h13;
    settle();
    chk("t1_i_rvalid", i_rvalid, 1);
    chk("t1_i_rdata", i_rdata, 64'h13);
    chk("t1_d_rvalid", d_rvalid, 0);
    tick();
    m_rvalid = 1'b0;

    // Simultaneous I and D: data first, responses in tag order.
    i_valid = 1'b1; i_addr = 64'h8000_0004;
    d_valid = 1'b1; d_addr = 64'h8000_1000; d_wen = 1'b1;
    d_wdata = {$urandom, $urandom}; d_wmask = 8'hff;
    settle();
    chk("t2_d_first", d_ready, 1);
    chk("t2_i_wait", i_ready, 0);
    chk("t2_m_addr_d", m_addr, 64'h8000_1000);
    tick();
    d_valid = 1'b0;
    settle();
    chk("t2_i_second", i_ready, 1);
    chk("t2_m_wen_i", m_wen, 0);
    tick();
    i_valid = 1'b0; m_rvalid = 1'b1; m_rdata = 64'hd0;
    settle();
    chk("t2_rsp1_d", d_rvalid, 1);
    tick();
    m_rdata = 64'h10;
    settle();
    chk("t2_rsp2_i", i_rvalid, 1);
    tick();
    m_rvalid = 1'b0; d_wen = 1'b0;

    // Back-pressure: stalled fetch pins the mux even when data arrives.
    m_ready = 1'b0; i_valid = 1'b1; i_addr = 64'h8000_0100;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t3_stall_addr", m_addr, 64'h8000_0100);
      tick();
    end
    d_valid = 1'b1; d_addr = 64'h8000_2000;
    settle();
    chk("t3_locked_addr", m_addr, 64'h8000_0100);
    tick();
    m_ready = 1'b1;
    settle();
    chk("t3_i_accept", i_ready, 1);
    chk("t3_d_hold", d_ready, 0);
    tick();
    i_valid = 1'b0;
    settle();
    chk("t3_d_after", d_ready, 1);
    chk("t3_m_addr_d", m_addr, 64'h8000_2000);
    tick();
    d_valid = 1'b0; m_rvalid = 1'b1;
    step();
    step();
    m_rvalid = 1'b0;

    // Outstanding limit.
    d_valid = 1'b1; d_addr = 64'h8000_3000; m_ready = 1'b1;
    step();
    step();
    settle();
    chk("t4_full_valid", m_valid, 0);
    tick();
    m_rvalid = 1'b1;
    settle();
    chk("t4_pop_no_free", m_valid, 0);
    tick();
    m_rvalid = 1'b0;
    settle();
    chk("t4_reassert", m_valid, 1);
    tick();
    d_valid = 1'b0; m_rvalid = 1'b1;
    step();
    step();
    m_rvalid = 1'b0;

    // Starvation: fetch forced through after LIMIT waiting cycles.
    i_valid = 1'b1; i_addr = 64'h8000_0200; d_valid = 1'b1; d_addr = 64'h8000_4000;
    for (int k = 0; k < 6; k++) begin
      m_rvalid = (k > 0);
      settle();
      chk("t5_i_ready", i_ready, k == 4);
      chk("t5_d_ready", d_ready, k != 4);
      tick();
    end
    i_valid = 1'b0; d_valid = 1'b0; m_rvalid = 1'b1;
    step();
    m_rvalid = 1'b0;

    // Reset with two requests in flight; the late response is discarded.
    d_valid = 1'b1; d_addr = 64'h8000_5000;
    step();
    step();
    d_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1; m_rvalid = 1'b1;
    settle();
    chk("t6_no_i_rvalid", i_rvalid, 0);
    chk("t6_no_d_rvalid", d_rvalid, 0);
    tick();
    m_rvalid = 1'b0; i_valid = 1'b1; i_addr = 64'h8000_0300;
    settle();
    chk("t6_slot1", m_valid, 1);
    tick();
    settle();
    chk("t6_slot2", m_valid, 1);
    tick();
    settle();
    chk("t6_full_again", m_valid, 0);
    tick();
    i_valid = 1'b0; m_rvalid = 1'b1;
    step();
    step();
    m_rvalid = 1'b0;

    // Randomized traffic against the model; requesters hold until accepted.
    i_pend = 1'b0;
    d_pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1'b1;
        i_addr = {$urandom, $urandom};
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend  = 1'b1;
        d_addr  = {$urandom, $urandom};
        d_wen   = 1'($urandom_range(0, 1));
        d_wdata = {$urandom, $urandom};
        d_wmask = 8'($urandom_range(0, 255));
      end
      i_valid  = i_pend;
      d_valid  = d_pend;
      m_ready  = ($urandom_range(0, 3) != 0);
      m_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      m_rdata  = {$urandom, $urandom};
      step();
      if (acc_i) i_pend = 1'b0;
      if (acc_d) d_pend = 1'b0;
    end

    i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_rvalid = (q.size() > 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
